// File: rtl/lifo_fifo_buffer_if.sv
// lifo_fifo_buffer_if: the control, data and status bundle of lifo_fifo_buffer.
//   master : drives init, mode, push, pop, d_in and observes status/data.
//   slave  : the buffer itself; drives d_out, d_valid, empty, full, count,
//            err_over and err_under.
// WIDTH and DEPTH must match the parameters of the attached buffer.
interface lifo_fifo_buffer_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             init;
  logic             mode;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             err_over;
  logic             err_under;

  modport master (
    output init, mode, push, pop, d_in,
    input  d_out, d_valid, empty, full, count, err_over, err_under
  );

  modport slave (
    input  init, mode, push, pop, d_in,
    output d_out, d_valid, empty, full, count, err_over, err_under
  );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// lifo_fifo_buffer: DEPTH x WIDTH storage usable as a stack (mode 0) or a
// queue (mode 1). Mode is latched only while the buffer is empty.
// Ports:
//   CLK  - clock, all state changes on the rising edge
//   RST  - asynchronous active-high reset
//   bus  - lifo_fifo_buffer_if.slave:
//          init (sync clear), mode, push, pop, d_in        (inputs)
//          d_out (registered pop data), d_valid (1-cycle pop strobe),
//          empty, full, count, err_over, err_under (sticky) (outputs)
module lifo_fifo_buffer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
) (
  input logic                 CLK,
  input logic                 RST,
  lifo_fifo_buffer_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             d_valid_q, d_valid_d;
  logic             mode_q, mode_d;
  logic             err_over_q, err_over_d;
  logic             err_under_q, err_under_d;

  logic             is_empty, is_full;
  logic             mode_eff;
  logic             pop_acc, push_acc;
  logic [CNT_W-1:0] top_cnt;
  logic [PTR_W-1:0] top_addr;
  logic [PTR_W-1:0] rd_addr, wr_addr;
  logic             mem_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  always_comb begin
    // While empty the incoming mode is already in force, so a push in the
    // same cycle lands where the new mode expects it.
    mode_eff = is_empty ? bus.mode : mode_q;
    pop_acc  = bus.pop && !is_empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push_acc = bus.push && (!is_full || pop_acc);

    top_cnt  = count_q - CNT_W'(1);
    top_addr = top_cnt[PTR_W-1:0];
    rd_addr  = mode_eff ? rd_ptr_q : top_addr;
    // Stack push+pop replaces the current top instead of growing.
    if (mode_eff)     wr_addr = wr_ptr_q;
    else if (pop_acc) wr_addr = top_addr;
    else              wr_addr = count_q[PTR_W-1:0];

    mem_we      = 1'b0;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    d_out_d     = d_out_q;
    d_valid_d   = 1'b0;
    mode_d      = mode_q;
    err_over_d  = err_over_q;
    err_under_d = err_under_q;

    if (bus.init) begin
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      d_out_d     = '0;
      mode_d      = 1'b0;
      err_over_d  = 1'b0;
      err_under_d = 1'b0;
    end else begin
      if (is_empty) mode_d = bus.mode;
      mem_we = push_acc;
      if (pop_acc) begin
        d_out_d   = mem_q[rd_addr];
        d_valid_d = 1'b1;
      end
      if (push_acc && !pop_acc) count_d = count_q + CNT_W'(1);
      if (pop_acc && !push_acc) count_d = count_q - CNT_W'(1);
      // Queue pointers move only in queue mode; they stay equal when empty.
      if (mode_eff) begin
        if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (bus.push && !push_acc) err_over_d  = 1'b1;
      if (bus.pop  && !pop_acc)  err_under_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      d_out_q     <= '0;
      d_valid_q   <= 1'b0;
      mode_q      <= 1'b0;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      d_out_q     <= d_out_d;
      d_valid_q   <= d_valid_d;
      mode_q      <= mode_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_addr] <= bus.d_in;
  end

  assign bus.d_out     = d_out_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.err_over  = err_over_q;
  assign bus.err_under = err_under_q;
endmodule

// File: tb/tb_lifo_fifo_buffer.sv
module tb_lifo_fifo_buffer;
  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  lifo_fifo_buffer_if #(.WIDTH(8), .DEPTH(4)) bus ();

  lifo_fifo_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [7:0] d);
    chk({tag, "_dout"}, bus.d_out, d);
    chk({tag, "_dvalid"}, {7'd0, bus.d_valid}, 8'd1);
  endtask

  task automatic chk_cnt(input string tag, input int n);
    chk({tag, "_count"}, 8'(bus.count), 8'(n));
    chk({tag, "_empty"}, {7'd0, bus.empty}, (n == 0) ? 8'd1 : 8'd0);
    chk({tag, "_full"},  {7'd0, bus.full},  (n == 4) ? 8'd1 : 8'd0);
  endtask

  task automatic chk_err(input string tag, input logic o, input logic u);
    chk({tag, "_err_over"},  {7'd0, bus.err_over},  {7'd0, o});
    chk({tag, "_err_under"}, {7'd0, bus.err_under}, {7'd0, u});
  endtask

  // One clock: drive request, take the edge, settle 1 time unit, release.
  task automatic cyc(input logic pu, input logic po, input logic [7:0] d);
    bus.push = pu;
    bus.pop  = po;
    bus.d_in = d;
    @(posedge CLK);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_init();
    bus.init = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    bus.init = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    bus.init = 1'b0;
    bus.mode = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.d_in = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk_cnt("reset", 0);
    chk("reset_dout", bus.d_out, 8'h00);
    chk("reset_dvalid", {7'd0, bus.d_valid}, 8'd0);
    chk_err("reset", 1'b0, 1'b0);
    RST = 1'b0;

    // Stack fill and drain
    bus.mode = 1'b0;
    cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33); cyc(1, 0, 8'h44);
    chk_cnt("lifo_fill", 4);
    cyc(0, 1, 8'h00); chk_pop("lifo_p1", 8'h44);
    cyc(0, 1, 8'h00); chk_pop("lifo_p2", 8'h33);
    cyc(0, 1, 8'h00); chk_pop("lifo_p3", 8'h22);
    cyc(0, 1, 8'h00); chk_pop("lifo_p4", 8'h11);
    chk_cnt("lifo_drain", 0);
    cyc(0, 0, 8'h00);
    chk("lifo_idle_dvalid", {7'd0, bus.d_valid}, 8'd0);
    chk("lifo_idle_dout", bus.d_out, 8'h11);

    // Queue with pointer wrap
    bus.mode = 1'b1;
    cyc(1, 0, 8'hA1); cyc(1, 0, 8'hA2); cyc(1, 0, 8'hA3);
    cyc(0, 1, 8'h00); chk_pop("fifo_p1", 8'hA1);
    cyc(0, 1, 8'h00); chk_pop("fifo_p2", 8'hA2);
    cyc(1, 0, 8'hB1); cyc(1, 0, 8'hB2); cyc(1, 0, 8'hB3);
    chk_cnt("fifo_wrapfill", 4);
    cyc(0, 1, 8'h00); chk_pop("fifo_p3", 8'hA3);
    cyc(0, 1, 8'h00); chk_pop("fifo_p4", 8'hB1);
    cyc(0, 1, 8'h00); chk_pop("fifo_p5", 8'hB2);
    cyc(0, 1, 8'h00); chk_pop("fifo_p6", 8'hB3);
    chk_cnt("fifo_drain", 0);
    chk_err("fifo_clean", 1'b0, 1'b0);

    // Overflow / underflow stickiness
    cyc(1, 0, 8'hC1); cyc(1, 0, 8'hC2); cyc(1, 0, 8'hC3); cyc(1, 0, 8'hC4);
    cyc(1, 0, 8'hC5);
    chk_cnt("ovf", 4);
    chk_err("ovf", 1'b1, 1'b0);
    cyc(0, 1, 8'h00); chk_pop("ovf_p1", 8'hC1);
    cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00); chk_pop("ovf_p4", 8'hC4);
    cyc(0, 1, 8'h00);
    chk("unf_dvalid", {7'd0, bus.d_valid}, 8'd0);
    chk("unf_dout", bus.d_out, 8'hC4);
    chk_cnt("unf", 0);
    chk_err("unf", 1'b1, 1'b1);
    cyc(0, 0, 8'h00);
    chk_err("sticky", 1'b1, 1'b1);
    do_init();
    chk_err("init", 1'b0, 1'b0);
    chk_cnt("init", 0);
    chk("init_dout", bus.d_out, 8'h00);

    // Stack push+pop replaces the top
    bus.mode = 1'b0;
    cyc(1, 0, 8'h10); cyc(1, 0, 8'h20);
    cyc(1, 1, 8'h30);
    chk_pop("lifo_pp", 8'h20);
    chk_cnt("lifo_pp", 2);
    cyc(0, 1, 8'h00); chk_pop("lifo_pp_n1", 8'h30);
    cyc(0, 1, 8'h00); chk_pop("lifo_pp_n2", 8'h10);
    chk_cnt("lifo_pp_end", 0);

    // Queue push+pop while full
    bus.mode = 1'b1;
    cyc(1, 0, 8'hD1); cyc(1, 0, 8'hD2); cyc(1, 0, 8'hD3); cyc(1, 0, 8'hD4);
    cyc(1, 1, 8'hD5);
    chk_pop("fifo_pp", 8'hD1);
    chk_cnt("fifo_pp", 4);
    chk_err("fifo_pp", 1'b0, 1'b0);
    cyc(0, 1, 8'h00); chk_pop("fifo_pp_n1", 8'hD2);
    cyc(0, 1, 8'h00); chk_pop("fifo_pp_n2", 8'hD3);
    cyc(0, 1, 8'h00); chk_pop("fifo_pp_n3", 8'hD4);
    cyc(0, 1, 8'h00); chk_pop("fifo_pp_n4", 8'hD5);
    chk_cnt("fifo_pp_end", 0);

    // Push+pop while empty: push wins, pop flagged
    cyc(1, 1, 8'hE1);
    chk_cnt("empty_pp", 1);
    chk("empty_pp_dvalid", {7'd0, bus.d_valid}, 8'd0);
    chk_err("empty_pp", 1'b0, 1'b1);
    cyc(0, 1, 8'h00); chk_pop("empty_pp_n", 8'hE1);
    do_init();

    // Mode change ignored while non-empty, honoured once empty
    bus.mode = 1'b0;
    cyc(1, 0, 8'h01); cyc(1, 0, 8'h02);
    bus.mode = 1'b1;
    cyc(0, 1, 8'h00); chk_pop("gate_p1", 8'h02);
    cyc(0, 1, 8'h00); chk_pop("gate_p2", 8'h01);
    cyc(1, 0, 8'h01); cyc(1, 0, 8'h02);
    cyc(0, 1, 8'h00); chk_pop("gate_p3", 8'h01);
    cyc(0, 1, 8'h00); chk_pop("gate_p4", 8'h02);

    // Asynchronous reset between edges
    cyc(1, 0, 8'h61); cyc(1, 0, 8'h62); cyc(1, 0, 8'h63);
    chk_cnt("pre_rst", 3);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_cnt("async_rst", 0);
    chk("async_rst_dout", bus.d_out, 8'h00);
    chk("async_rst_dvalid", {7'd0, bus.d_valid}, 8'd0);
    #2;
    RST = 1'b0;
    cyc(1, 0, 8'h55);
    chk_cnt("post_rst_push", 1);
    cyc(0, 1, 8'h00); chk_pop("post_rst_pop", 8'h55);
    chk_cnt("post_rst_end", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lifo_fifo_buffer.md
Name: lifo_fifo_buffer

Overview:
Parametrised storage buffer that generalises the team's stack block. It adds run-time LIFO/FIFO mode selection, full flag, occupancy count, and registered pop data with a valid strobe. It also defines simultaneous push/pop behaviour and sticky overflow/underflow flags. It sits between the datapath and controller FSMs anywhere an operand or trail store is needed.

Parameters:
WIDTH, 2, data word width in bits (>=1)
DEPTH, 256, number of entries (>=2, need not be a power of two)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
init  input  1  synchronous clear, same effect as RST on the next edge
mode  input  1  0 = LIFO, 1 = FIFO; sampled only while empty
push  input  1  write request for d_in
pop  input  1  read request
d_in  input  WIDTH  data to store
d_out  output  WIDTH  last popped word, registered
d_valid  output  1  high for exactly one cycle after each accepted pop
empty  output  1  count == 0, combinational from count
full  output  1  count == DEPTH, combinational from count
count  output  $clog2(DEPTH+1)  current occupancy
err_over  output  1  sticky overflow flag
err_under  output  1  sticky underflow flag

Behaviour:
- RST (async) or init (sync, highest priority over push/pop) clears the following to 0: count, d_out, d_valid, err_over, err_under, mode_q, rd_ptr, wr_ptr. Storage array is not cleared.
- mode_q register: loads mode on every edge where count == 0 at the start of the cycle. A push in that same cycle uses the new mode. Changes of mode while non-empty are ignored.
- LIFO addressing: push writes mem[count]; pop reads mem[count-1].
- FIFO addressing: push writes mem[wr_ptr]; pop reads mem[rd_ptr].
- FIFO pointer wrap: each pointer wraps from DEPTH-1 to 0. When the buffer is empty, rd_ptr == wr_ptr at any value.
- Accepted pop = pop && !empty. Accepted push = push && (!full || accepted pop).
- Pop latency: on an accepted pop, d_out <= popped word at the edge and d_valid = 1 for that following cycle only. Otherwise d_out holds its value and d_valid = 0.
- Push only: store d_in; count +1.
- Pop only: count -1; pointers/top updated.
- Push+pop, non-empty, FIFO: d_out <= mem[rd_ptr]; d_in written at wr_ptr; both pointers advance; count unchanged. This applies when full as well.
- Push+pop, non-empty, LIFO: d_out <= old top mem[count-1]; d_in overwrites mem[count-1]; count unchanged. This applies when full as well.
- Push+pop while empty: push accepted (count becomes 1); pop rejected; d_valid = 0; err_under set.
- Push while full without pop: write ignored; count stays DEPTH; err_over set.
- Pop while empty: ignored; d_out holds; d_valid = 0; err_under set.
- err_over and err_under stay high until RST or init.
- count never exceeds DEPTH and never goes below 0.
- RST asserted mid-operation clears state immediately. The first edge after RST deasserts behaves as from empty.

Test Plan:
- Bench configuration: WIDTH=8, DEPTH=4.
- LIFO fill/drain (mode=0): push 0x11,0x22,0x33,0x44 -> full=1, count=4. Pop x4 -> d_out 0x44,0x33,0x22,0x11, each with a 1-cycle d_valid pulse. Then empty=1.
- FIFO wrap (mode=1): push A1,A2,A3; pop 2 -> A1,A2; push B1,B2,B3 -> count=4, full=1, wr_ptr wrapped. Pop 4 -> A3,B1,B2,B3.
- Error flags: push 5 words -> 5th ignored, err_over=1, count=4. Drain, then pop once more -> err_under=1, d_valid=0, d_out=last value. Pulse init -> both flags 0, count=0.
- Simultaneous push+pop:
  - LIFO holding 0x10,0x20: push 0x30 with pop -> d_out=0x20, count=2; next pop -> 0x30.
  - FIFO full: push+pop -> count stays 4, order preserved.
  - Empty: push+pop -> count=1, err_under=1.
- Mode gating: LIFO with 2 entries, drive mode=1 -> pops remain LIFO order. After empty, mode=1 takes effect; push 1,2 -> pop order 1,2.
- Async reset mid-burst: assert RST between clock edges with count=3 -> outputs zero immediately. After release, a push of 0x55 then pop -> d_out=0x55.
